// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the E stage: multi-cycle multiply, 32-step restoring divide,
// holds {hi, lo} in DONE until the instruction leaves E, aborts on flush.
module mdu_ctrl #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_ITERS  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        E_start,
  input  logic [1:0]  E_op,
  input  logic [31:0] E_src_a,
  input  logic [31:0] E_src_b,
  input  logic        E_ena,
  input  logic        E_flush,
  output logic        E_alu_stall,
  output logic [31:0] E_hi,
  output logic [31:0] E_lo,
  output logic        E_result_valid,
  output logic        E_div_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int CNT_MAX = (MUL_CYCLES > DIV_ITERS) ? MUL_CYCLES : DIV_ITERS;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      opa_reg;      // multiplicand, or dividend/quotient shift register
  logic [31:0]      opb_reg;      // multiplier, or divisor magnitude
  logic [31:0]      rem_reg;
  logic             mul_signed_reg;
  logic             neg_q_reg;
  logic             neg_r_reg;
  logic [31:0]      hi_reg;
  logic [31:0]      lo_reg;
  logic             div_zero_reg;

  // Sign-extending to 64 bits lets a plain 64-bit multiply give the exact low 64 product bits.
  logic [63:0] mul_a, mul_b, product;
  assign mul_a   = {{32{mul_signed_reg & opa_reg[31]}}, opa_reg};
  assign mul_b   = {{32{mul_signed_reg & opb_reg[31]}}, opb_reg};
  assign product = mul_a * mul_b;

  logic [32:0] rem_shift;
  logic        rem_ge;
  logic [31:0] rem_next, quo_next, quo_fix, rem_fix;
  assign rem_shift = {rem_reg, opa_reg[31]};
  assign rem_ge    = rem_shift >= {1'b0, opb_reg};
  assign rem_next  = rem_ge ? 32'(rem_shift - {1'b0, opb_reg}) : rem_shift[31:0];
  assign quo_next  = {opa_reg[30:0], rem_ge};
  assign quo_fix   = neg_q_reg ? -quo_next : quo_next;
  assign rem_fix   = neg_r_reg ? -rem_next : rem_next;

  logic        div_signed;
  logic [31:0] a_mag, b_mag;
  assign div_signed = ~E_op[0];
  assign a_mag = (div_signed & E_src_a[31]) ? -E_src_a : E_src_a;
  assign b_mag = (div_signed & E_src_b[31]) ? -E_src_b : E_src_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      hi_reg         <= '0;
      lo_reg         <= '0;
      div_zero_reg   <= 1'b0;
      opa_reg        <= '0;
      opb_reg        <= '0;
      rem_reg        <= '0;
      mul_signed_reg <= 1'b0;
      neg_q_reg      <= 1'b0;
      neg_r_reg      <= 1'b0;
    end else if (E_flush) begin
      state_reg    <= IDLE;
      div_zero_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (E_start) begin
            div_zero_reg <= 1'b0;
            if (!E_op[1]) begin
              opa_reg        <= E_src_a;
              opb_reg        <= E_src_b;
              mul_signed_reg <= ~E_op[0];
              cnt_reg        <= CNT_W'(MUL_CYCLES - 1);
              state_reg      <= MUL;
            end else if (E_src_b != 32'd0) begin
              opa_reg   <= a_mag;
              opb_reg   <= b_mag;
              rem_reg   <= '0;
              neg_q_reg <= div_signed & (E_src_a[31] ^ E_src_b[31]);
              neg_r_reg <= div_signed & E_src_a[31];
              cnt_reg   <= CNT_W'(DIV_ITERS - 1);
              state_reg <= DIV;
            end else begin
              hi_reg       <= E_src_a;
              lo_reg       <= 32'hFFFF_FFFF;
              div_zero_reg <= 1'b1;
              state_reg    <= DONE;
            end
          end
        end
        MUL: begin
          if (cnt_reg == '0) begin
            hi_reg    <= product[63:32];
            lo_reg    <= product[31:0];
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        DIV: begin
          rem_reg <= rem_next;
          opa_reg <= quo_next;
          if (cnt_reg == '0) begin
            hi_reg    <= rem_fix;
            lo_reg    <= quo_fix;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: begin
          // DONE: E_start still belongs to the finished instruction, so only E_ena moves us on.
          if (E_ena) state_reg <= IDLE;
        end
      endcase
    end
  end

  assign E_alu_stall    = ~rst & (((state_reg == IDLE) & E_start & ~E_flush) |
                                  (state_reg == MUL) | (state_reg == DIV));
  assign E_result_valid = (state_reg == DONE);
  assign E_hi           = hi_reg;
  assign E_lo           = lo_reg;
  assign E_div_zero     = div_zero_reg;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: driver pushes model results, negedge monitor pops and compares
// on each rising E_result_valid.
module tb_mdu_ctrl;

  localparam int MUL_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        E_start;
  logic [1:0]  E_op;
  logic [31:0] E_src_a;
  logic [31:0] E_src_b;
  logic        E_ena;
  logic        E_flush;
  logic        E_alu_stall;
  logic [31:0] E_hi;
  logic [31:0] E_lo;
  logic        E_result_valid;
  logic        E_div_zero;

  mdu_ctrl #(.MUL_CYCLES(MUL_CYCLES), .DIV_ITERS(32)) dut (
    .clk(clk), .rst(rst), .E_start(E_start), .E_op(E_op), .E_src_a(E_src_a),
    .E_src_b(E_src_b), .E_ena(E_ena), .E_flush(E_flush), .E_alu_stall(E_alu_stall),
    .E_hi(E_hi), .E_lo(E_lo), .E_result_valid(E_result_valid), .E_div_zero(E_div_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    int          start;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic; SV '/' and '%' truncate toward zero,
  // which gives exactly the MIPS quotient/remainder signs.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb2, p;
    longint unsigned ua, ub, up;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    e.op = op; e.a = a; e.b = b; e.dz = 1'b0; e.start = 0;
    e.lat = op[1] ? ((b == 32'd0) ? 1 : 33) : MUL_CYCLES + 1;
    case (op)
      2'd0: begin p = sa * sb2; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'd1: begin up = ua * ub; e.hi = up[63:32]; e.lo = up[31:0]; end
      2'd2: begin
        if (b == 32'd0) begin e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1; end
        else begin p = sa / sb2; e.lo = p[31:0]; p = sa % sb2; e.hi = p[31:0]; end
      end
      default: begin
        if (b == 32'd0) begin e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1; end
        else begin up = ua / ub; e.lo = up[31:0]; up = ua % ub; e.hi = up[31:0]; end
      end
    endcase
    return e;
  endfunction

  // Monitor: one scoreboard pop per completed result.
  logic valid_q = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      if (E_result_valid && !valid_q) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_result", 32'(E_result_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          $display("txn op=%0d a=%h b=%h hi=%h lo=%h dz=%b lat=%0d", e.op, e.a, e.b,
                   E_hi, E_lo, E_div_zero, cyc - e.start);
          chk("hi", E_hi, e.hi);
          chk("lo", E_lo, e.lo);
          chk("div_zero", 32'(E_div_zero), 32'(e.dz));
          chk("latency", 32'(cyc - e.start), 32'(e.lat));
        end
      end
      valid_q <= E_result_valid;
    end
  end

  task automatic drive_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    E_start = 1'b1; E_op = op; E_src_a = a; E_src_b = b; E_ena = 1'b0; E_flush = 1'b0;
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit flush_exit);
    exp_t e;
    bit   stall_ok = 1'b1;
    bit   got = 1'b0;
    e = model(op, a, b);
    drive_start(op, a, b);
    e.start = cyc;
    sb_q.push_back(e);
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (E_result_valid) begin got = 1'b1; break; end
      if (!E_alu_stall) stall_ok = 1'b0;
    end
    if (!got) begin
      chk("done_timeout", 32'(got), 32'd1);
    end else begin
      chk("stall_busy", 32'(stall_ok), 32'd1);
      chk("stall_done", 32'(E_alu_stall), 32'd0);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_valid", 32'(E_result_valid), 32'd1);
      chk("hold_stall", 32'(E_alu_stall), 32'd0);
    end
    @(posedge clk); #1;
    if (flush_exit) E_flush = 1'b1; else E_ena = 1'b1;
    @(posedge clk); #1;
    E_flush = 1'b0; E_start = 1'b0; E_ena = 1'b0;
    @(negedge clk);
    chk("exit_valid", 32'(E_result_valid), 32'd0);
    chk("exit_stall", 32'(E_alu_stall), 32'd0);
    if (flush_exit) chk("exit_div_zero", 32'(E_div_zero), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;

    rst = 1'b1; E_start = 1'b1; E_op = 2'd0; E_src_a = 32'd3; E_src_b = 32'd4;
    E_ena = 1'b0; E_flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_stall", 32'(E_alu_stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; E_start = 1'b0;
    @(negedge clk);
    chk("reset_hi", E_hi, 32'd0);
    chk("reset_lo", E_lo, 32'd0);
    chk("reset_valid", 32'(E_result_valid), 32'd0);
    chk("reset_div_zero", 32'(E_div_zero), 32'd0);

    do_op(2'd0, 32'hFFFF_FFFE, 32'd3, 0, 1'b0);
    do_op(2'd1, 32'hFFFF_FFFE, 32'd3, 1, 1'b0);

    // Reset during MUL clears everything, including the last result.
    drive_start(2'd0, 32'd5, 32'd7);
    @(posedge clk); #1;
    E_start = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("midrst_stall", 32'(E_alu_stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_hi", E_hi, 32'd0);
    chk("midrst_lo", E_lo, 32'd0);
    chk("midrst_valid", 32'(E_result_valid), 32'd0);
    chk("midrst_stall_after", 32'(E_alu_stall), 32'd0);

    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    do_op(2'd3, 32'd100, 32'd7, 5, 1'b0);
    do_op(2'd2, 32'h0000_1234, 32'd0, 0, 1'b0);
    do_op(2'd2, 32'h0000_1234, 32'd0, 2, 1'b1);
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);

    // Flush mid-divide at T+10, then a MULTU must still work.
    drive_start(2'd2, 32'd1000, 32'd3);
    repeat (10) begin @(posedge clk); #1; end
    E_flush = 1'b1;
    @(posedge clk); #1;
    E_flush = 1'b0; E_start = 1'b0;
    @(negedge clk);
    chk("flush_stall", 32'(E_alu_stall), 32'd0);
    chk("flush_valid", 32'(E_result_valid), 32'd0);
    do_op(2'd1, 32'd5, 32'd6, 0, 1'b0);

    // Start together with flush in IDLE must not launch an op.
    drive_start(2'd1, 32'd9, 32'd9);
    E_flush = 1'b1;
    @(negedge clk);
    chk("startflush_stall", 32'(E_alu_stall), 32'd0);
    @(posedge clk); #1;
    E_flush = 1'b0; E_start = 1'b0;
    @(negedge clk);
    chk("startflush_idle", 32'(E_alu_stall), 32'd0);
    repeat (4) @(posedge clk);

    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: a = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      do_op(op, a, b, int'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0));
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Sequencer for the multiply/divide unit in the E stage of the dual-issue pipeline.
- Accepts a MULT/MULTU/DIV/DIVU op from E, runs the multi-cycle multiply or a 32-iteration restoring divide, and drives E_alu_stall into the hazard unit while busy.
- Holds {hi, lo} until the instruction leaves E (E_ena), so the op is never re-issued while E is frozen by other stalls.
- Aborts cleanly on an E-stage flush.

Parameters:
- MUL_CYCLES, 2, cycles spent in MUL state (pipelined multiplier depth, ≥1).
- DIV_ITERS, 32, restoring-divide iterations (fixed to data width).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- E_start  in  1  muldiv op present and valid in E this cycle.
- E_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- E_src_a  in  32  rs operand (dividend / multiplicand).
- E_src_b  in  32  rt operand (divisor / multiplier).
- E_ena  in  1  E stage advances this cycle.
- E_flush  in  1  E-stage instruction is being killed this cycle.
- E_alu_stall  out  1  to hazard unit; high while the result is not ready.
- E_hi  out  32  HI result.
- E_lo  out  32  LO result.
- E_result_valid  out  1  E_hi/E_lo hold the finished result.
- E_div_zero  out  1  finished op was a divide by zero.

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous, active-high.
- Reset values:
  - state = IDLE, counter = 0.
  - E_hi = E_lo = 0, E_result_valid = 0, E_div_zero = 0.
  - E_alu_stall = 0 in any cycle where rst = 1.
- States: IDLE, MUL, DIV, DONE.
- Stall: E_alu_stall is combinational and equals (IDLE & E_start & ~E_flush) | MUL | DIV. It is low in DONE.
- IDLE:
  - E_start & ~E_flush → latch operands and op.
  - op[1] = 0 → MUL with counter = MUL_CYCLES-1.
  - op[1] = 1, E_src_b ≠ 0 → DIV with counter = DIV_ITERS-1.
  - op[1] = 1, E_src_b = 0 → DONE directly, with E_hi = E_src_a, E_lo = 32'hFFFF_FFFF, E_div_zero = 1.
- MUL:
  - Decrement the counter each cycle.
  - At counter = 0 → DONE, loading the 64-bit product: E_hi = product[63:32], E_lo = product[31:0].
  - MULT sign-extends both operands to 33 bits; MULTU zero-extends.
- DIV:
  - On entry, operands are converted to magnitudes (|x| for DIV, raw for DIVU).
  - Each cycle performs one restoring shift-subtract step on a 33-bit partial remainder.
  - After the step at counter = 0 → DONE with sign fix-up:
    - quotient is negated iff DIV and the operand signs differ;
    - remainder takes the sign of the dividend (DIV only).
  - E_lo = quotient, E_hi = remainder.
  - Corner case: DIV 0x8000_0000 / -1 gives lo = 0x8000_0000, hi = 0.
- DONE:
  - E_result_valid = 1.
  - E_ena = 1 → IDLE next cycle; E_result_valid drops then.
  - E_ena = 0 → hold all outputs. E_start stays high for the same instruction and must not restart the op.
- Latency, with the start cycle = T:
  - Multiply: DONE and stall low at T+MUL_CYCLES+1.
  - Divide: DONE at T+DIV_ITERS+1 (T+33).
  - Divide by zero: DONE at T+1.
- Back-to-back ops: a new op can start in the IDLE cycle right after the DONE→IDLE transition.
- Flush: E_flush = 1 in any state → IDLE next cycle with E_result_valid = 0 and E_div_zero = 0. No start from IDLE when E_flush = 1. E_flush takes priority over E_ena and E_start.
- rst mid-operation: same effect as flush, plus E_hi/E_lo cleared.
- E_hi/E_lo are only meaningful while E_result_valid = 1. They hold their last value in IDLE, except after reset.

Test Plan:
- MULT: a=0xFFFF_FFFE (-2), b=3, start at T → stall high T..T+2; at T+3 valid=1, hi=0xFFFF_FFFF, lo=0xFFFF_FFFA. MULTU with the same operands → hi=0x0000_0002, lo=0xFFFF_FFFA.
- DIV: a=-7 (0xFFFF_FFF9), b=2 → stall high 33 cycles; at T+33 lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1). DIVU 100/7 → lo=14, hi=2.
- Hold: a DIVU completes while E_ena = 0 for 5 further cycles with E_start held high → stays in DONE, valid=1, stall=0, no restart. E_ena=1 → IDLE next cycle.
- Divide by zero: DIV a=0x1234, b=0 → valid at T+1, hi=0x1234, lo=0xFFFF_FFFF, E_div_zero=1.
- Flush mid-divide: E_flush pulsed at T+10 → next cycle IDLE, stall=0, valid=0. A following MULTU 5×6 then completes with lo=30, hi=0.
- Reset: rst asserted during MUL → next cycle IDLE, all outputs 0. Also cover E_start with E_flush in the same IDLE cycle → no start and stall=0.
